// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_WIDTH data bits, LSB first, run-time
// parity (none/even/odd) and 1 or 2 stop bits. Bit timing is counted in
// i_tick pulses. A one-entry holding buffer lets frames run back to back.
// Handshake: a word is accepted on a rising clk edge where i_tx_signal and
// o_tx_ready are both high; o_tx_ready depends only on the holding buffer,
// never on i_tx_signal, and a request while o_tx_ready is low is dropped.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_CNT_W = $clog2(2 * OVERSAMPLE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic                  i_tx_signal,
    input  logic [DATA_WIDTH-1:0] i_data_byte,
    input  logic [1:0]            i_parity_mode,
    input  logic                  i_stop_two,
    output logic                  o_tx_ready,
    output logic                  o_tx_busy,
    output logic                  o_tx_done_bit,
    output logic                  o_tx_data,
    output logic [2:0]            o_dbg_state
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [TICK_CNT_W-1:0] LAST_TICK_1 = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [TICK_CNT_W-1:0] LAST_TICK_2 = TICK_CNT_W'(2 * OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]      LAST_BIT    = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_hold_valid, w_hold_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_hold_data;
    logic [1:0]              r_hold_mode;
    logic                    r_hold_stop2;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
    logic                    r_par_bit, w_par_bit_nxt;
    logic                    r_par_en, w_par_en_nxt;
    logic                    r_stop2, w_stop2_nxt;
    logic [TICK_CNT_W-1:0]   r_tick_cnt, w_tick_cnt_nxt;
    logic [IDX_W-1:0]        r_bit_idx, w_bit_idx_nxt;
    logic                    r_tx_data, w_tx_data_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_accept;
    logic                    w_load;

    assign w_accept      = i_tx_signal && !r_hold_valid;
    assign o_tx_ready    = !r_hold_valid;
    assign o_tx_busy     = (r_state != IDLE);
    assign o_tx_done_bit = r_done;
    assign o_tx_data     = r_tx_data;
    assign o_dbg_state   = r_state;

    // Holding buffer: capture word and its frame config together on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_data  <= '0;
            r_hold_mode  <= 2'b00;
            r_hold_stop2 <= 1'b0;
        end else if (w_accept) begin
            r_hold_data  <= i_data_byte;
            r_hold_mode  <= i_parity_mode;
            r_hold_stop2 <= i_stop_two;
        end
    end

    // Next-state, counters and serial output value for the frame FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_bit_nxt  = r_par_bit;
        w_par_en_nxt   = r_par_en;
        w_stop2_nxt    = r_stop2;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        w_tx_data_nxt  = 1'b1;

        case (r_state)
            IDLE: begin
                if (r_hold_valid) w_load = 1'b1;
            end
            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == LAST_TICK_1) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_idx_nxt  = '0;
                        w_state_nxt    = DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_tick_cnt == LAST_TICK_1) begin
                        w_tick_cnt_nxt = '0;
                        w_shift_nxt    = {1'b0, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            w_state_nxt = r_par_en ? PARITY : STOP;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (i_tick) begin
                    if (r_tick_cnt == LAST_TICK_1) begin
                        w_tick_cnt_nxt = '0;
                        w_state_nxt    = STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == (r_stop2 ? LAST_TICK_2 : LAST_TICK_1)) begin
                        w_tick_cnt_nxt = '0;
                        w_done_nxt     = 1'b1;
                        if (r_hold_valid) w_load = 1'b1;
                        else              w_state_nxt = IDLE;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Loading a buffered word starts a new frame; parity is fixed here so
        // later config changes cannot touch the frame in flight.
        if (w_load) begin
            w_state_nxt    = START;
            w_shift_nxt    = r_hold_data;
            w_par_bit_nxt  = (^r_hold_data) ^ (r_hold_mode == 2'b10);
            w_par_en_nxt   = (r_hold_mode == 2'b01) || (r_hold_mode == 2'b10);
            w_stop2_nxt    = r_hold_stop2;
            w_tick_cnt_nxt = '0;
            w_bit_idx_nxt  = '0;
        end

        w_hold_valid_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_valid);

        case (w_state_nxt)
            START:   w_tx_data_nxt = 1'b0;
            DATA:    w_tx_data_nxt = w_shift_nxt[0];
            PARITY:  w_tx_data_nxt = w_par_bit_nxt;
            default: w_tx_data_nxt = 1'b1;
        endcase
    end

    // Frame state registers; reset aborts any frame and drives the line idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_par_en     <= 1'b0;
            r_stop2      <= 1'b0;
            r_tick_cnt   <= '0;
            r_bit_idx    <= '0;
            r_tx_data    <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_shift      <= w_shift_nxt;
            r_par_bit    <= w_par_bit_nxt;
            r_par_en     <= w_par_en_nxt;
            r_stop2      <= w_stop2_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_done       <= w_done_nxt;
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Serialises DATA_WIDTH-bit words LSB-first with run-time selectable parity (none/even/odd) and 1 or 2 stop bits. Bit timing comes from the oversampling tick of the existing baud-rate generator. A one-entry holding buffer with a ready/valid handshake allows back-to-back frames with no idle gap.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9
OVERSAMPLE, 16, i_tick pulses per bit period; legal >= 2
TICK_CNT_W, $clog2(2*OVERSAMPLE), width of the tick counter (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
i_tick  input  1  oversample enable from the baud generator, one clk wide
i_tx_signal  input  1  valid: request to send i_data_byte
i_data_byte  input  DATA_WIDTH  word to transmit; captured on accept
i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
i_stop_two  input  1  0 = one stop bit, 1 = two stop bits
o_tx_ready  output  1  holding buffer empty; accept occurs when i_tx_signal && o_tx_ready at a clk edge
o_tx_busy  output  1  high while a frame is on the line (state != IDLE)
o_tx_done_bit  output  1  one-clk pulse when the last stop bit completes
o_tx_data  output  1  serial line, registered, idle high

Behaviour:
- Reset (reset=0, async): o_tx_data=1, o_tx_done_bit=0, o_tx_busy=0, o_tx_ready=1; holding buffer and shift register cleared; state IDLE. Reset mid-frame aborts the frame and drives the line high immediately; the buffered word is discarded.
- Holding buffer: o_tx_ready = !hold_valid (combinational). On accept, i_data_byte, i_parity_mode and i_stop_two are latched together. i_tx_signal while o_tx_ready=0 is ignored; there is no overwrite.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE with hold_valid set: on the next edge, move the buffer into the shift register and the frame config, clear hold_valid, enter START, and set o_tx_data=0. Frame start latency is 1 clk after accept when idle.
- Tick counter advances only on clk edges with i_tick=1. i_tick is ignored in IDLE.
- START: line 0 for OVERSAMPLE ticks, then enter DATA with bit index 0.
- DATA: line = shift[0] for OVERSAMPLE ticks per bit, shifting right. After DATA_WIDTH bits, enter PARITY if mode is 01 or 10; otherwise enter STOP.
- PARITY: even mode sends XOR of the latched data; odd mode sends its inverse. Lasts OVERSAMPLE ticks.
- STOP: line 1 for OVERSAMPLE ticks (one stop bit) or 2*OVERSAMPLE ticks (two stop bits). On the final tick:
  - o_tx_done_bit=1 for exactly one clk.
  - If hold_valid is set, go directly to START on the same edge (line 0 next clk, new word loaded, buffer freed). Otherwise go to IDLE.
- Frame duration = OVERSAMPLE*(1 + DATA_WIDTH + P + S) ticks, where P = 1 if parity is enabled and S = number of stop bits.
- Config inputs affect only words accepted after they change; the frame in flight is unaffected.
- Data is transmitted LSB first. Upper bits beyond DATA_WIDTH do not exist; widths are exact.

Test Plan:
1. DATA_WIDTH=8, OVERSAMPLE=16, tick every 4 clk; send 8'b11101010, mode 00, 1 stop -> line 0,0,1,0,1,0,1,1,1,1, each bit 16 ticks (64 clk); done pulse once, 160 ticks after START; busy drops, ready=1.
2. Same word, mode 01 -> parity bit 1 (five ones) after bit 7, then stop. Mode 10 -> parity bit 0. Frame = 176 ticks.
3. i_stop_two=1, word 8'h00, mode 00 -> line high for 32 ticks before done; total 176 ticks.
4. Back-to-back: accept 8'h55, then 8'hA3 while the first is in DATA -> ready low after second accept; after the first frame's stop bit, line goes 0 on the next clk with no idle bit; received words 0x55 then 0xA3; two done pulses 160 ticks apart.
5. Overflow: with the frame active and buffer full, pulse i_tx_signal with 8'hFF -> ignored; only the two earlier words appear on the line.
6. Assert reset during DATA bit 3 -> o_tx_data=1, busy=0, ready=1 without waiting for a clk edge; no done pulse; the next send of 8'h3C (DATA_WIDTH=7 instance: 7'h3C) transmits correctly.
